multi_hand_datapath: RTL
========================

# multi_hand_datapath

Parametrised successor to the fixed two-hand, three-card baccarat datapath. It holds `NUM_HANDS` independent hands of up to `MAX_CARDS` cards each. Dealt cards are routed to a hand by index instead of by per-slot load strobes, and each hand keeps a running modulo-10 score, card count, full flag and natural flag. It sits between the card source (`dealcard`) and the game controller, and its card outputs feed the `card7seg` decoders.

## Interface
Parameters:
- `NUM_HANDS`, default 2: number of hands; legal range 1..8.
- `MAX_CARDS`, default 3: card slots per hand; legal range 2..7.
- `IDX_W`, derived: `max(1, $clog2(NUM_HANDS))`.
- `CNT_W`, derived: `$clog2(MAX_CARDS+1)`.

Ports:
- `clock` in 1: single clock; all state changes on the rising edge.
- `resetb` in 1: reset is asynchronous and active-low.
- `clear` in 1: synchronous clear of all hands, for a new round.
- `deal_valid` in 1: a deal request is present this cycle.
- `deal_hand` in `IDX_W`: index of the target hand.
- `new_card` in 4: card code; 1=A, 2..10, 11=J, 12=Q, 13=K.
- `deal_ack` out 1: one-cycle pulse; the deal was accepted.
- `deal_err` out 1: one-cycle pulse; the deal was rejected.
- `err_sticky` out 1: set by any rejection; cleared by `clear` or reset.
- `cards_out` out `NUM_HANDS*MAX_CARDS*4`: hand h, slot s occupies bits `[(h*MAX_CARDS+s)*4 +: 4]`; an empty slot is 0.
- `count_out` out `NUM_HANDS*CNT_W`: cards held by hand h, at `[h*CNT_W +: CNT_W]`.
- `score_out` out `NUM_HANDS*4`: baccarat score (0..9) of hand h, at `[h*4 +: 4]`.
- `full_out` out `NUM_HANDS`: bit h is 1 when count of hand h equals `MAX_CARDS`.
- `natural_out` out `NUM_HANDS`: bit h is 1 when count of hand h is 2 and its score is 8 or 9.
- `last_card` out 4: value of the most recently accepted card; 0 after reset or clear.

## Operation
- **Per-hand state:**
  - `MAX_CARDS` 4-bit slot registers;
  - a count register of `CNT_W` bits, which also serves as the write pointer;
  - a 4-bit score register.
- **Card point value:** the card code if it is 1..9; 0 for codes 10..13.
- **Score update:**
  - compute `sum = score + value`, held in 5 bits (maximum 18);
  - the new score is `sum - 10` if `sum >= 10`, otherwise `sum`;
  - the update uses the registered score plus the incoming card in the same cycle, so no extra adder stage is needed.
- **Accept condition:** all of the following hold:
  - `deal_valid` is 1;
  - `clear` is 0;
  - `deal_hand < NUM_HANDS`;
  - `new_card` is in 1..13;
  - the target hand is not full.
- **On accept:**
  - write the card into `slot[count]` of the target hand;
  - increment that hand's count and update its score;
  - load `last_card`;
  - pulse `deal_ack`.
  - No other hand changes.
- **Reject:** any deal with `deal_valid` = 1 and `clear` = 0 that fails the accept condition:
  - no hand state changes;
  - `deal_err` pulses and `err_sticky` sets.
- **`clear`:** on the next edge, zero all slots, counts, scores, `last_card` and `err_sticky`. `deal_ack` and `deal_err` are 0 on that edge.
- **Simultaneous `clear` and `deal_valid`:** `clear` wins; the deal is dropped silently, with neither ack nor err.
- **Derived flags:** `full_out` and `natural_out` are combinational decodes of the registered count and score, so they are glitch-free relative to state.

## Timing
- **Reset:**
  - `resetb` low forces all registers to 0 immediately, without waiting for a clock edge;
  - all outputs are 0 during reset, including `full_out` and `natural_out`;
  - state is released on the first rising edge after `resetb` goes high.
- **Deal latency:**
  - for a deal presented in cycle k, slots, count, score, `last_card` and `deal_ack`/`deal_err` are all valid after edge k;
  - `deal_ack`/`deal_err` are high for exactly one cycle;
  - there is no ready signal; every cycle can accept a deal.
- **Back-to-back deals:** consecutive cycles to the same hand must accumulate correctly, with the second deal using the score written by the first.
- **Filling the last slot:** a deal in the cycle a hand becomes full is accepted. A deal in the following cycle to that hand is rejected.
- **No wrap-around:** the count saturates at `MAX_CARDS`; slot 0 is never overwritten except by `clear` or reset.
- **Reset mid-round:** asserting reset mid-round discards all hands, and any `deal_ack`/`deal_err` pulse in flight is removed at once.

## Test plan
- **Basic two-hand deal:** defaults; after reset, deal hand0 cards 9 then 6.
  - Expect `count_out`[hand0]=2, `score_out`[hand0]=5, `deal_ack` pulsed twice.
- **Natural:** deal hand1 cards 13 then 8.
  - Expect score 8, `natural_out`[1]=1, `full_out`[1]=0.
  - A third card 1 gives score 9, count 3, `natural_out`[1]=0, `full_out`[1]=1.
- **Full hand:** a fourth deal to the full hand1.
  - Expect `deal_err`=1 for one cycle, `err_sticky`=1, and hand1 slots, count and score unchanged.
- **Invalid input:** `new_card`=0 or 14, and `deal_hand`=3 with `NUM_HANDS`=3.
  - Each request is rejected with a `deal_err` pulse; no hand state changes.
- **Clear priority:** assert `clear` and `deal_valid` in the same cycle.
  - All counts, scores and slots are 0, `err_sticky`=0, and there is no ack or err.
- **Parametrised case and async reset:** `NUM_HANDS`=4, `MAX_CARDS`=5; interleave back-to-back deals across hands, then drop `resetb` between clock edges.
  - Before reset, verify per-hand slot packing and scores against a reference model.
  - On reset, outputs must go to 0 before the next edge.

Source files
------------

// File: rtl/multi_hand_datapath.sv
// multi_hand_datapath: NUM_HANDS independent baccarat hands of up to
// MAX_CARDS cards each. A deal is routed to one hand by index. Each hand
// keeps its slots, a count that doubles as the write pointer, and a running
// modulo-10 score. The full and natural flags decode the registered state.

// One hand: slot registers, count/write pointer and running score.
module multi_hand_datapath_hand #(
  parameter int MAX_CARDS = 3,
  parameter int CNT_W     = 2
) (
  input  logic                   clock,
  input  logic                   resetb,
  input  logic                   clear_i,
  input  logic                   wr_en_i,
  input  logic [3:0]             card_i,
  output logic [MAX_CARDS*4-1:0] slots_o,
  output logic [CNT_W-1:0]       cnt_o,
  output logic [3:0]             score_o,
  output logic                   full_o,
  output logic                   natural_o
);
  logic [MAX_CARDS-1:0][3:0] slots_q, slots_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [3:0]                score_q, score_d;
  logic [3:0]                value;
  logic [4:0]                sum;
  logic [3:0]                score_nxt;

  // Point value and next score, computed from the registered score so that
  // back-to-back deals to this hand accumulate in a single cycle each.
  always_comb begin
    value     = (card_i <= 4'd9) ? card_i : 4'd0;
    sum       = {1'b0, score_q} + {1'b0, value};
    score_nxt = (sum >= 5'd10) ? 4'(sum - 5'd10) : sum[3:0];
  end

  // Next state: clear zeroes the hand; an accepted deal fills slot[count].
  always_comb begin
    slots_d = slots_q;
    cnt_d   = cnt_q;
    score_d = score_q;
    if (clear_i) begin
      slots_d = '0;
      cnt_d   = '0;
      score_d = '0;
    end else if (wr_en_i) begin
      for (int s = 0; s < MAX_CARDS; s++)
        if (cnt_q == CNT_W'(s)) slots_d[s] = card_i;
      cnt_d   = cnt_q + CNT_W'(1);
      score_d = score_nxt;
    end
  end

  // Hand state registers.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      slots_q <= '0;
      cnt_q   <= '0;
      score_q <= '0;
    end else begin
      slots_q <= slots_d;
      cnt_q   <= cnt_d;
      score_q <= score_d;
    end
  end

  // The top only enables writes when the hand is not full, so the count
  // saturates at MAX_CARDS and slot 0 is never overwritten.
  assign slots_o   = slots_q;
  assign cnt_o     = cnt_q;
  assign score_o   = score_q;
  assign full_o    = (cnt_q == CNT_W'(MAX_CARDS));
  assign natural_o = (cnt_q == CNT_W'(2)) && (score_q >= 4'd8);
endmodule

// Top: deal routing, accept/reject decision, pulses and last-card register.
module multi_hand_datapath #(
  parameter int NUM_HANDS = 2,
  parameter int MAX_CARDS = 3,
  localparam int IDX_W    = (NUM_HANDS > 1) ? $clog2(NUM_HANDS) : 1,
  localparam int CNT_W    = $clog2(MAX_CARDS + 1)
) (
  input  logic                             clock,
  input  logic                             resetb,
  input  logic                             clear,
  input  logic                             deal_valid,
  input  logic [IDX_W-1:0]                 deal_hand,
  input  logic [3:0]                       new_card,
  output logic                             deal_ack,
  output logic                             deal_err,
  output logic                             err_sticky,
  output logic [NUM_HANDS*MAX_CARDS*4-1:0] cards_out,
  output logic [NUM_HANDS*CNT_W-1:0]       count_out,
  output logic [NUM_HANDS*4-1:0]           score_out,
  output logic [NUM_HANDS-1:0]             full_out,
  output logic [NUM_HANDS-1:0]             natural_out,
  output logic [3:0]                       last_card
);
  logic [NUM_HANDS-1:0] hand_sel;
  logic                 hand_ok, card_ok, tgt_full;
  logic                 accept, reject;
  logic                 ack_q, ack_d, err_q, err_d, sticky_q, sticky_d;
  logic [3:0]           last_q, last_d;

  // One-hot decode of the target hand; an out-of-range index selects none.
  for (genvar h = 0; h < NUM_HANDS; h++) begin : g_sel
    assign hand_sel[h] = (deal_hand == IDX_W'(h));
  end

  // Accept/reject decision; clear drops a concurrent deal silently.
  always_comb begin
    hand_ok  = ({1'b0, deal_hand} < (IDX_W+1)'(NUM_HANDS));
    card_ok  = (new_card != 4'd0) && (new_card <= 4'd13);
    tgt_full = |(full_out & hand_sel);
    accept   = deal_valid && !clear && hand_ok && card_ok && !tgt_full;
    reject   = deal_valid && !clear && !(hand_ok && card_ok && !tgt_full);
  end

  // Next state of the shared control registers.
  always_comb begin
    ack_d    = accept;
    err_d    = reject;
    sticky_d = clear ? 1'b0 : (sticky_q | reject);
    last_d   = clear ? 4'd0 : (accept ? new_card : last_q);
  end

  // Shared control registers; reset removes any pulse in flight at once.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
      last_q   <= 4'd0;
    end else begin
      ack_q    <= ack_d;
      err_q    <= err_d;
      sticky_q <= sticky_d;
      last_q   <= last_d;
    end
  end

  for (genvar h = 0; h < NUM_HANDS; h++) begin : g_hand
    multi_hand_datapath_hand #(
      .MAX_CARDS (MAX_CARDS),
      .CNT_W     (CNT_W)
    ) u_hand (
      .clock     (clock),
      .resetb    (resetb),
      .clear_i   (clear),
      .wr_en_i   (accept && hand_sel[h]),
      .card_i    (new_card),
      .slots_o   (cards_out[h*MAX_CARDS*4 +: MAX_CARDS*4]),
      .cnt_o     (count_out[h*CNT_W +: CNT_W]),
      .score_o   (score_out[h*4 +: 4]),
      .full_o    (full_out[h]),
      .natural_o (natural_out[h])
    );
  end

  assign deal_ack   = ack_q;
  assign deal_err   = err_q;
  assign err_sticky = sticky_q;
  assign last_card  = last_q;
endmodule
